// File: rtl/osc_fsm_multi.sv
// -----------------------------------------------------------------------------
// osc_fsm_multi
//   Multi-channel oscillator. While a[i] is held high, channel i drives a square
//   wave on y[i] with HALF_PERIOD cycles high followed by HALF_PERIOD cycles low.
//   Once a period has started it always runs to the end, so dropping a[i]
//   mid-period never produces a runt pulse. The channels are independent and
//   share only the global advance enable.
//
// Optional feature (compile-time macro OSC_BURST_LIMIT_EN):
//   Each request is limited to MAX_PERIODS periods. After the last period the
//   channel parks in HOLD (y=0, busy=1) until a[i] drops, so a new burst needs
//   a fresh rising request. Without the macro, oscillation continues for as
//   long as a[i] stays high.
//
// Parameters
//   CHANNELS     number of independent channels (>=1)
//   HALF_PERIOD  cycles y[i] spends high, then low, in each period (>=1)
//   MAX_PERIODS  periods per request, only used with OSC_BURST_LIMIT_EN (>=1)
//
// Ports
//   clk   in   1         system clock, rising edge
//   rst   in   1         asynchronous reset, active low
//   en    in   1         global advance enable; 0 freezes every channel
//   a     in   CHANNELS  per-channel oscillate request (level)
//   y     out  CHANNELS  per-channel square wave (decoded from state register)
//   busy  out  CHANNELS  channel is not idle
//   done  out  CHANNELS  one-cycle strobe on the last low cycle of each period
// -----------------------------------------------------------------------------
module osc_fsm_multi #(
  parameter int CHANNELS    = 4,
  parameter int HALF_PERIOD = 2,
  parameter int MAX_PERIODS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] a,
  output logic [CHANNELS-1:0] y,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  // Phase counter width; a 1-cycle half period still gets a 1-bit counter.
  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Reject nonsensical configurations at elaboration time.
  if (CHANNELS < 1 || HALF_PERIOD < 1 || MAX_PERIODS < 1) begin : g_bad_param
    $error("osc_fsm_multi: CHANNELS, HALF_PERIOD and MAX_PERIODS must all be >= 1");
  end

`ifdef OSC_BURST_LIMIT_EN
  localparam int PW = $clog2(MAX_PERIODS + 1);
  localparam logic [PW-1:0] PCNT_MAX = PW'(MAX_PERIODS);
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_last;
`ifdef OSC_BURST_LIMIT_EN
    logic [PW-1:0] pcnt_q, pcnt_d;
`endif

    assign cnt_last = (cnt_q == CNT_LAST);

    // State register. The whole channel freezes while en is low, so the
    // enable gates the update here rather than in the next-state logic.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
`ifdef OSC_BURST_LIMIT_EN
        pcnt_q  <= '0;
`endif
      end else if (en) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
`ifdef OSC_BURST_LIMIT_EN
        pcnt_q  <= pcnt_d;
`endif
      end
    end

    // Next-state logic.
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef OSC_BURST_LIMIT_EN
      pcnt_d  = pcnt_q;
`endif
      case (state_q)
`ifdef OSC_BURST_LIMIT_EN
        IDLE: begin
          if (a[i]) begin
            state_d = HIGH;
            cnt_d   = '0;
            pcnt_d  = '0;
          end
        end
`else
        // HOLD cannot be reached without the burst limit; should it ever be
        // entered it behaves exactly like IDLE.
        IDLE, HOLD: begin
          if (a[i]) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
`endif
        HIGH: begin
          if (cnt_last) begin
            state_d = LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOW: begin
          if (cnt_last) begin
            // End of a period: the request is only re-examined here, which
            // is what guarantees every started period completes.
            cnt_d = '0;
`ifdef OSC_BURST_LIMIT_EN
            pcnt_d = pcnt_q + 1'b1;
            if (pcnt_d == PCNT_MAX) begin
              state_d = HOLD;
            end else begin
              state_d = a[i] ? HIGH : IDLE;
            end
`else
            state_d = a[i] ? HIGH : IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef OSC_BURST_LIMIT_EN
        HOLD: begin
          // Burst exhausted: wait for the request to drop before re-arming.
          if (!a[i]) begin
            state_d = IDLE;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Output decode straight from the state register.
    assign y[i]    = (state_q == HIGH);
`ifdef OSC_BURST_LIMIT_EN
    assign busy[i] = (state_q != IDLE);
`else
    assign busy[i] = (state_q == HIGH) || (state_q == LOW);
`endif
    // done is qualified by en so it fires once per period even if the channel
    // is frozen on its last low cycle.
    assign done[i] = (state_q == LOW) && cnt_last && en;
  end

endmodule

// File: tb/tb_osc_fsm_multi.sv
// -----------------------------------------------------------------------------
// tb_osc_fsm_multi
//   Directed bench for osc_fsm_multi with CHANNELS=2, HALF_PERIOD=2,
//   MAX_PERIODS=3. Outputs are sampled 1 time unit after each rising edge and
//   inputs are changed at the same point. Expectations follow the burst limit
//   macro OSC_BURST_LIMIT_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_osc_fsm_multi;

  localparam int CHANNELS    = 2;
  localparam int HALF_PERIOD = 2;
  localparam int MAX_PERIODS = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en  = 1'b1;
  logic [CHANNELS-1:0] a   = '0;
  logic [CHANNELS-1:0] y;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] done;

  int checks = 0;
  int errors = 0;

  osc_fsm_multi #(
    .CHANNELS   (CHANNELS),
    .HALF_PERIOD(HALF_PERIOD),
    .MAX_PERIODS(MAX_PERIODS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .a   (a),
    .y   (y),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CHANNELS-1:0] observed,
                       input logic [CHANNELS-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_outs(input string tag, input logic [CHANNELS-1:0] ey,
                            input logic [CHANNELS-1:0] eb,
                            input logic [CHANNELS-1:0] ed);
    check({tag, ".y"}, y, ey);
    check({tag, ".busy"}, busy, eb);
    check({tag, ".done"}, done, ed);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Channel 0 outputs {y, busy, done} after the k-th edge (k>=1) of a request
  // held high from IDLE: period of 4 cycles, high on phases 0-1, done on 3.
  function automatic logic [2:0] burst_exp(input int k);
    int ph;
    ph = (k - 1) % (2 * HALF_PERIOD);
`ifdef OSC_BURST_LIMIT_EN
    if (k > 2 * HALF_PERIOD * MAX_PERIODS) return 3'b010;
`endif
    return {ph < HALF_PERIOD, 1'b1, ph == 2 * HALF_PERIOD - 1};
  endfunction

  task automatic run_burst(input string tag, input int n);
    logic [2:0] e;
    for (int k = 1; k <= n; k++) begin
      step();
      e = burst_exp(k);
      check_outs($sformatf("%s[%0d]", tag, k), {1'b0, e[2]}, {1'b0, e[1]},
                 {1'b0, e[0]});
    end
  endtask

  initial begin
    // ---- 1. reset with requests pending ----
    #1 rst = 1'b0;
    a = 2'b11;
    #2;
    check_outs("rst_hold", 2'b00, 2'b00, 2'b00);
    step();
    step();
    check_outs("rst_edges", 2'b00, 2'b00, 2'b00);
    rst = 1'b1;
    #1;
    check_outs("rst_release", 2'b00, 2'b00, 2'b00);
    step();
    check_outs("first_edge", 2'b11, 2'b11, 2'b00);
    #2 rst = 1'b0;
    #1;
    check_outs("async_clear", 2'b00, 2'b00, 2'b00);
    a   = 2'b00;
    rst = 1'b1;
    step();
    check_outs("idle_after_rst", 2'b00, 2'b00, 2'b00);

    // ---- 3. single-cycle request still produces a full period ----
    a = 2'b01;
    step();
    check_outs("pulse_e1", 2'b01, 2'b01, 2'b00);
    a = 2'b00;
    step();
    check_outs("pulse_e2", 2'b01, 2'b01, 2'b00);
    step();
    check_outs("pulse_e3", 2'b00, 2'b01, 2'b00);
    step();
    check_outs("pulse_e4", 2'b00, 2'b01, 2'b01);
    step();
    check_outs("pulse_idle", 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) begin
      step();
      check_outs("pulse_quiet", 2'b00, 2'b00, 2'b00);
    end

    // ---- 2/4. held request: continuous wave, or 3-period burst then HOLD ----
    a = 2'b01;
    run_burst("held", 20);
    a = 2'b00;
    step();
    check_outs("held_drop", 2'b00, 2'b00, 2'b00);
    a = 2'b01;
    run_burst("rearm", 13);
    a = 2'b00;
    for (int k = 0; k < 5; k++) step();
    check_outs("rearm_idle", 2'b00, 2'b00, 2'b00);

    // ---- 5. en freezes the channel and masks done ----
    a = 2'b01;
    step();
    check_outs("en_h1", 2'b01, 2'b01, 2'b00);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_outs("en_frozen", 2'b01, 2'b01, 2'b00);
    end
    en = 1'b1;
    step();
    check_outs("en_h2", 2'b01, 2'b01, 2'b00);
    step();
    check_outs("en_l1", 2'b00, 2'b01, 2'b00);
    step();
    check_outs("en_l2", 2'b00, 2'b01, 2'b01);
    en = 1'b0;
    #1;
    check("en_done_mask", done, 2'b00);
    step();
    check_outs("en_l2_frozen", 2'b00, 2'b01, 2'b00);
    en = 1'b1;
    #1;
    check("en_done_back", done, 2'b01);
    a = 2'b00;
    step();
    check_outs("en_idle", 2'b00, 2'b00, 2'b00);

    // ---- 6. async reset mid-operation, then independent restart ----
    a = 2'b10;
    step();
    step();
    a = 2'b11;
    step();
    check_outs("mid_before", 2'b01, 2'b11, 2'b00);
    #2 rst = 1'b0;
    #1;
    check_outs("mid_rst", 2'b00, 2'b00, 2'b00);
    a = 2'b10;
    step();
    check_outs("mid_rst_edge", 2'b00, 2'b00, 2'b00);
    rst = 1'b1;
    step();
    check_outs("restart_e1", 2'b10, 2'b10, 2'b00);
    a = 2'b11;
    step();
    check_outs("restart_e2", 2'b11, 2'b11, 2'b00);
    step();
    check_outs("restart_e3", 2'b01, 2'b11, 2'b00);
    step();
    check_outs("restart_e4", 2'b00, 2'b11, 2'b10);
    a = 2'b00;
    step();
    check_outs("restart_e5", 2'b00, 2'b01, 2'b01);
    step();
    check_outs("restart_idle", 2'b00, 2'b00, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
